// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction-memory program loader.
package loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles big-endian words from accepted bytes and keeps the running XOR of every data byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic [BYTE_W-1:0] xor_sum,
    output logic              word_done
);

    logic [LANE_W-1:0]        lane_q;
    logic [WORD_W-BYTE_W-1:0] shift_q;
    logic [BYTE_W-1:0]        xor_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q  <= '0;
            shift_q <= '0;
            xor_q   <= '0;
        end else if (clear) begin
            lane_q  <= '0;
            shift_q <= '0;
            xor_q   <= '0;
        end else if (accept) begin
            lane_q  <= lane_q + LANE_W'(1);
            shift_q <= word[WORD_W-BYTE_W-1:0];
            xor_q   <= xor_q ^ byte_in;
        end
    end

    // The current byte completes the word combinationally so it can be registered on accept.
    assign word      = {shift_q, byte_in};
    assign xor_sum   = xor_q;
    assign word_done = accept && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes instruction words and holds the core in reset
// until a complete, checksum-verified program is in memory.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CAPACITY = 1 << ADDR_W;
    localparam int unsigned CNT_W    = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_q, count_q;
    logic              wr_en_q;
    logic [WORD_W-1:0] wr_data_q;
    logic              accept, pack_accept, hdr_bad, last_word, csum_ok, word_done;
    logic [WORD_W-1:0] word;
    logic [BYTE_W-1:0] xor_sum;

    // start wins over a byte offered in the same cycle
    assign byte_ready  = state_q inside {HDR, DATA, CSUM};
    assign accept      = byte_valid && byte_ready && !start;
    assign pack_accept = accept && (state_q == DATA);
    assign hdr_bad     = (byte_data == '0) || (32'(byte_data) > CAPACITY);
    assign last_word   = (count_q + CNT_W'(1)) == n_q;
    assign csum_ok     = byte_data == xor_sum;

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .accept    (pack_accept),
        .byte_in   (byte_data),
        .word      (word),
        .xor_sum   (xor_sum),
        .word_done (word_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = HDR;
        end else begin
            case (state_q)
                HDR:     if (accept) state_d = hdr_bad ? ERR : DATA;
                DATA:    if (word_done && last_word) state_d = CSUM;
                CSUM:    if (accept) state_d = csum_ok ? DONE : ERR;
                default: ;
            endcase
        end
    end

    // count_q advances as wr_en drops, so wr_addr holds the slot being written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q       <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= word_done;
            if (word_done) wr_data_q <= word;
            if (start) begin
                count_q <= '0;
            end else if (wr_en_q) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (state_q == HDR && accept && !hdr_bad) n_q <= CNT_W'(byte_data);
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = count_q[ADDR_W-1:0];
    assign wr_data    = wr_data_q;
    assign word_count = count_q;
    assign core_reset = state_q != DONE;
    assign done       = state_q == DONE;
    assign error      = state_q == ERR;

endmodule
